// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing generator gated by PLL lock
//
// Purpose:
//   Produces hsync/vsync/data-enable, pixel coordinates and line/frame strobes
//   from free-running horizontal and vertical counters. A two-state control FSM
//   holds the raster idle (counters at 0, outputs inactive) until the video PLL
//   reports lock. Losing lock abandons the current frame. Relocking always
//   restarts at pixel (0,0) with a frame_start pulse.
//
// Ports:
//   clk          in   pixel clock (25 MHz video PLL output)
//   rst          in   synchronous active-high reset, has priority over pll_locked
//   pll_locked   in   PLL lock indication, already synchronous to clk
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   de           out  high during visible pixels
//   x            out  pixel column while de=1, else 0
//   y            out  pixel row while de=1, else 0
//   line_start   out  one-cycle pulse on the first visible pixel of each visible line
//   frame_start  out  one-cycle pulse on pixel (0,0)
//
//   All outputs are registered from the counters: the outputs in cycle n+1
//   describe the counter value of cycle n.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries sized to the counter width so every compare is CW bits.
  localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // ------------------------------------------------------------------
  // Control FSM and raster counters
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Counters are pinned at 0 so the first RUN cycle is pixel (0,0).
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (pll_locked) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!pll_locked) begin
          // Abandon the frame; there is no resume point on relock.
          state_d = ST_IDLE;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          // Both wraps happen on the same edge at the last pixel of the frame.
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
          end else begin
            v_cnt_d = v_cnt_q + CW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Output decode of the current counter value (registered below)
  // ------------------------------------------------------------------
  logic running;
  logic h_vis;
  logic v_vis;
  logic h_sync_win;
  logic v_sync_win;

  always_comb begin
    running    = (state_q == ST_RUN);
    h_vis      = (h_cnt_q < H_ACT_C);
    v_vis      = (v_cnt_q < V_ACT_C);
    h_sync_win = (h_cnt_q >= H_HS_BEG) && (h_cnt_q < H_HS_END);
    // vsync spans whole lines, so it depends on v_cnt only.
    v_sync_win = (v_cnt_q >= V_VS_BEG) && (v_cnt_q < V_VS_END);

    de_d          = running && h_vis && v_vis;
    hsync_d       = (running && h_sync_win) ? SYNC_ON : SYNC_OFF;
    vsync_d       = (running && v_sync_win) ? SYNC_ON : SYNC_OFF;
    x_d           = de_d ? h_cnt_q : '0;
    y_d           = de_d ? v_cnt_q : '0;
    line_start_d  = running && (h_cnt_q == '0) && v_vis;
    frame_start_d = running && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // ------------------------------------------------------------------
  // State, counter and output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
//
// Instance a: reduced raster (H 8/2/3/2 = 15, V 6/1/2/1 = 10), active-low syncs.
// Instance b: same raster, active-high syncs.
// Instance c: default 640x480 raster, used for full-size line timing.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;

  always #20 clk = ~clk;

  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       hs_c, vs_c, de_c, ls_c, fs_c;
  logic [9:0] x_c, y_c;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .CW(10)
  ) u_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .CW(10)
  ) u_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen u_c (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .x(x_c), .y(y_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  typedef struct {
    logic       rst;
    logic       lock;
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t vecs[21];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic r, logic l, logic hs, logic vs, logic de,
                              int x, int y, logic ls, logic fs);
    vec_t v;
    v.rst = r; v.lock = l; v.hs = hs; v.vs = vs; v.de = de;
    v.x = 10'(x); v.y = 10'(y); v.ls = ls; v.fs = fs;
    return v;
  endfunction

  function automatic int pk(logic hs, logic vs, logic de, logic [9:0] x,
                            logic [9:0] y, logic ls, logic fs);
    return int'({hs, vs, de, x, y, ls, fs});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle/reset output images for instance a (active-low) and b (active-high).
  int idle_a;
  int idle_b;

  initial begin
    int fs1, fs2, a_ls, a_vs_low, a_vs_first, a_de, a_xmax, a_ymax;
    int b_hs_high, b_vs_high, b_de;
    int cls1, cls2, c_de, c_hs_low, c_hs_first;
    bit found;
    bit stayed_idle;

    idle_a = pk(1, 1, 0, 0, 0, 0, 0);
    idle_b = pk(0, 0, 0, 0, 0, 0, 0);

    // Reset, release, first line of instance a (one output per h_cnt value).
    for (int i = 0; i < 4; i++) vecs[i] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[4] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[5] = mk(0, 1, 1, 1, 1, 0, 0, 1, 1);
    for (int h = 1; h < 8; h++) vecs[5 + h] = mk(0, 1, 1, 1, 1, h, 0, 0, 0);
    vecs[13] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int h = 10; h < 13; h++) vecs[5 + h] = mk(0, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 1, 1, 1, 0, 1, 1, 0);

    rst = 1'b1;
    pll_locked = 1'b1;

    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst;
      pll_locked = vecs[i].lock;
      tick();
      chk($sformatf("vec%0d_a", i), pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a),
          pk(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].ls, vecs[i].fs));
      chk($sformatf("vec%0d_b", i), pk(hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b),
          pk(~vecs[i].hs, ~vecs[i].vs, vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].ls, vecs[i].fs));
      if (i == 0) chk("reset_sync_c", int'({hs_c, vs_c}), 3);
    end

    // Free-running measurements: one full frame of a/b, one full line of c.
    fs1 = -1; fs2 = -1; a_ls = 0; a_vs_low = 0; a_vs_first = -1; a_de = 0;
    a_xmax = 0; a_ymax = 0; b_hs_high = 0; b_vs_high = 0; b_de = 0;
    cls1 = -1; cls2 = -1; c_de = 0; c_hs_low = 0; c_hs_first = -1;
    for (int t = 0; t < 1700; t++) begin
      tick();
      if (fs_a) begin
        if (fs1 < 0) fs1 = t;
        else if (fs2 < 0) fs2 = t;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        if (ls_a) a_ls++;
        if (!vs_a) begin
          a_vs_low++;
          if (a_vs_first < 0) a_vs_first = t - fs1;
        end
        if (de_a) begin
          a_de++;
          if (int'(x_a) > a_xmax) a_xmax = int'(x_a);
          if (int'(y_a) > a_ymax) a_ymax = int'(y_a);
        end
        if (hs_b) b_hs_high++;
        if (vs_b) b_vs_high++;
        if (de_b) b_de++;
      end
      if (ls_c) begin
        if (cls1 < 0) cls1 = t;
        else if (cls2 < 0) cls2 = t;
      end
      if (cls1 >= 0 && cls2 < 0) begin
        if (de_c) c_de++;
        if (!hs_c) begin
          c_hs_low++;
          if (c_hs_first < 0) c_hs_first = t - cls1;
        end
      end
    end
    chk("a_frame_period", fs2 - fs1, 150);
    chk("a_line_starts", a_ls, 6);
    chk("a_vsync_low", a_vs_low, 30);
    chk("a_vsync_offset", a_vs_first, 105);
    chk("a_de_count", a_de, 48);
    chk("a_last_x", a_xmax, 7);
    chk("a_last_y", a_ymax, 5);
    chk("b_hsync_high", b_hs_high, 30);
    chk("b_vsync_high", b_vs_high, 30);
    chk("b_de_count", b_de, 48);
    chk("c_line_period", cls2 - cls1, 800);
    chk("c_de_count", c_de, 640);
    chk("c_hsync_low", c_hs_low, 96);
    chk("c_hsync_offset", c_hs_first, 656);

    // Lock loss at visible pixel (4,3) for 10 cycles.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick();
      if (de_a && x_a == 10'd4 && y_a == 10'd3) found = 1'b1;
    end
    chk("lockloss_find", int'(found), 1);
    pll_locked = 1'b0;
    tick();
    chk("lockloss_lag", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), pk(1, 1, 1, 5, 3, 0, 0));
    tick();
    chk("lockloss_idle_a", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), idle_a);
    chk("lockloss_idle_b", pk(hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b), idle_b);
    stayed_idle = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a) != idle_a) stayed_idle = 1'b0;
    end
    chk("lockloss_hold", int'(stayed_idle), 1);
    pll_locked = 1'b1;
    tick();
    chk("relock_first", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), idle_a);
    tick();
    chk("relock_origin", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), pk(1, 1, 1, 0, 0, 1, 1));
    tick();
    chk("relock_next", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), pk(1, 1, 1, 1, 0, 0, 0));

    // Reset asserted on the second vsync line.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick();
      if (!vs_a) found = 1'b1;
    end
    chk("vsync_find", int'(found), 1);
    for (int k = 0; k < 20; k++) tick();
    chk("vsync_line2", int'(vs_a), 0);
    rst = 1'b1;
    tick();
    chk("midrst_a", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), idle_a);
    chk("midrst_b", pk(hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b), idle_b);
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    tick();
    chk("rst_release_idle", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), idle_a);
    tick();
    chk("rst_restart", pk(hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a), pk(1, 1, 1, 0, 0, 1, 1));
    chk("rst_restart_c", pk(hs_c, vs_c, de_c, x_c, y_c, ls_c, fs_c), pk(1, 1, 1, 0, 0, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Consumes the 25 MHz video pixel clock from the video PLL and its lock indication. Generates 640x480@60 VGA raster timing: hsync, vsync, data-enable, pixel coordinates, and line/frame strobes. The frame-buffer reader and the colour output stage use these signals. Timing is held idle whenever the PLL is not locked, so no partial or garbled frame reaches the display.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low)
CW, 10, coordinate/counter width

Ports:
clk  in  1  pixel clock (25 MHz video PLL output)
rst  in  1  synchronous, active-high reset
pll_locked  in  1  lock indication from the video PLL; treated as synchronous to clk
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
de  out  1  high during visible pixels
x  out  CW  current pixel column (valid when de=1)
y  out  CW  current pixel row (valid when de=1)
line_start  out  1  one-cycle pulse on first visible pixel of each visible line
frame_start  out  1  one-cycle pulse on pixel (0,0) of each frame

Behaviour:
- One clock; reset is synchronous and active-high; ports named clk and rst.
- Derived constants: H_TOTAL = sum of all H_* (800); V_TOTAL = sum of all V_* (525).
- Internal counters: h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1, each CW bits wide.
- Counter update when running:
  - h_cnt increments each cycle.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt advances.
  - v_cnt wraps from V_TOTAL-1 to 0.
- All outputs are registered from the counters, so there is a 1-cycle latency. Outputs in cycle n+1 describe counter value n.
- Decode of counter state, as seen on the outputs one cycle later:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491); applies to whole lines
  - x = h_cnt and y = v_cnt when de=1; x and y hold 0 when de=0
  - line_start = (h_cnt==0) && (v_cnt < V_ACTIVE)
  - frame_start = (h_cnt==0) && (v_cnt==0)
- Two-state control FSM:
  - IDLE: counters held at 0; all outputs inactive.
  - RUN: counters advance as above.
- FSM transitions:
  - IDLE->RUN when pll_locked=1 and rst=0; counters are 0 in that first RUN cycle.
  - RUN->IDLE on any cycle pll_locked=0. Counters clear on the next edge; outputs go inactive one cycle later.
- Lock loss mid-frame: the frame is abandoned. On relock, timing restarts at (0,0) with a frame_start pulse; there is no resume.
- Reset values (and IDLE values) of all outputs:
  - hsync = vsync = ~SYNC_POL (inactive level)
  - de = 0, x = 0, y = 0
  - line_start = 0, frame_start = 0
- rst has priority over pll_locked. rst asserted mid-line forces IDLE and reset values on the next edge.
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on the same edge, with no intervening cycle.
- SYNC_POL=1 inverts only hsync and vsync. de and the strobes are always active-high.

Test Plan:
- Reset then lock: rst=1 for 4 cycles, pll_locked=1, release rst -> frame_start=1, de=1, x=0, y=0 exactly 1 cycle after the first RUN cycle; hsync=vsync=1 during reset.
- Line timing: count cycles from line_start -> de high for 640 cycles; hsync low for 96 cycles beginning 656 cycles after line_start; next line_start 800 cycles later.
- Frame timing: measure between frame_start pulses -> 420000 cycles; vsync low for 1600 cycles beginning 490*800 cycles after frame_start; 480 line_start pulses per frame; last visible pixel has x=639, y=479.
- Lock loss: drop pll_locked at (x=300, y=200) for 10 cycles, then restore -> outputs inactive within 2 cycles; on restore, frame_start fires and x/y restart at 0.
- Mid-operation reset: assert rst during vsync (v_cnt=491) -> next-cycle outputs all at reset values; restart after release matches the first scenario.
- Polarity: SYNC_POL=1 build -> hsync high for 96 cycles per line, idle level 0; de and strobe timing identical to default.
